// File: rtl/axi_slave_mem.sv
// AXI slave memory model standing in for the DRAM-cache backing store.
// Each line holds {tag, data}. Writes are byte-strobed with one write in
// flight. Reads are queued in order and returned after a fixed latency.
// IDs are echoed on R and B, and addresses above the indexed range get SLVERR.
module axi_slave_mem #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 16,
  parameter int TAG_W    = 64,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 6,
  parameter int RD_LAT   = 4,
  parameter int AR_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // AR channel
  input  logic [ID_W-1:0]           arid_i,
  input  logic [ADDR_W-1:0]         araddr_i,
  input  logic                      arvalid_i,
  output logic                      arready_o,
  // R channel
  output logic [ID_W-1:0]           rid_o,
  output logic [TAG_W+DATA_W-1:0]   rdata_o,
  output logic [1:0]                rresp_o,
  output logic                      rvalid_o,
  input  logic                      rready_i,
  // AW channel
  input  logic [ID_W-1:0]           awid_i,
  input  logic [ADDR_W-1:0]         awaddr_i,
  input  logic                      awvalid_i,
  output logic                      awready_o,
  // W channel
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [DATA_W/8-1:0]       wstrb_i,
  input  logic [TAG_W-1:0]          wtag_i,
  input  logic                      wvalid_i,
  output logic                      wready_o,
  // B channel
  output logic [ID_W-1:0]           bid_o,
  output logic [1:0]                bresp_o,
  output logic                      bvalid_o,
  input  logic                      bready_i
);

  localparam int LINE_W = TAG_W + DATA_W;
  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1 << INDEX_W;
  localparam int HI_LSB = INDEX_W + OFFSET_W;
  localparam int PTR_W  = $clog2(AR_DEPTH);
  localparam int CNT_W  = $clog2(RD_LAT + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Address decode: offset bits are ignored, any bit above the index is out of range.
  logic [INDEX_W-1:0] w_ar_index;
  logic [INDEX_W-1:0] w_aw_index;
  logic               w_ar_err;
  logic               w_aw_err;
  logic               w_unused;

  assign w_ar_index = araddr_i[HI_LSB-1:OFFSET_W];
  assign w_aw_index = awaddr_i[HI_LSB-1:OFFSET_W];
  assign w_ar_err   = |araddr_i[ADDR_W-1:HI_LSB];
  assign w_aw_err   = |awaddr_i[ADDR_W-1:HI_LSB];
  assign w_unused   = ^{araddr_i[OFFSET_W-1:0], awaddr_i[OFFSET_W-1:0]};

  // Backing store; starts at zero and survives reset.
  logic [LINE_W-1:0] r_mem [DEPTH] = '{default: '0};

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  w_state_e           r_wstate;
  logic               r_awready;
  logic               r_wready;
  logic               r_bvalid;
  logic [ID_W-1:0]    r_bid;
  logic [1:0]         r_bresp;
  logic [INDEX_W-1:0] r_windex;
  logic               r_werr;
  logic               w_wr_en;

  assign w_wr_en = (r_wstate == W_DATA) && wvalid_i && !r_werr;

  // Write FSM: AW capture, W accept, B response, with registered handshake outputs.
  // NOTE: sequential state is always assigned with <= so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= RESP_OKAY;
      r_windex  <= '0;
      r_werr    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (awvalid_i) begin
            r_bid     <= awid_i;
            r_bresp   <= w_aw_err ? RESP_SLVERR : RESP_OKAY;
            r_werr    <= w_aw_err;
            r_windex  <= w_aw_index;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid_i) begin
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready_i) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Array commit: strobed data bytes, tag field always written.
  // NOTE: the array has no reset branch; clearing a memory on reset would
  // force it into flops and would also wipe data that must survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_i[i]) r_mem[r_windex][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
      r_mem[r_windex][DATA_W +: TAG_W] <= wtag_i;
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  logic [ID_W-1:0]    r_q_id    [AR_DEPTH];
  logic [INDEX_W-1:0] r_q_index [AR_DEPTH];
  logic               r_q_err   [AR_DEPTH];
  logic [CNT_W-1:0]   r_q_cnt   [AR_DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [PTR_W:0]     r_count;

  logic               r_rvalid;
  logic [ID_W-1:0]    r_rid;
  logic [1:0]         r_rresp;
  logic [LINE_W-1:0]  r_rdata;

  logic               w_arready;
  logic               w_push;
  logic               w_pop;

  assign w_arready = (r_count != (PTR_W+1)'(AR_DEPTH));
  assign w_push    = arvalid_i && w_arready;
  assign w_pop     = (r_count != '0) && (r_q_cnt[r_head] == '0) && (!r_rvalid || rready_i);

  // Queue pointers and occupancy; reset discards all pending reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue entries: load on push, every countdown ticks toward zero each cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < AR_DEPTH; i++) begin
      if (w_push && (r_tail == PTR_W'(i))) begin
        r_q_id[i]    <= arid_i;
        r_q_index[i] <= w_ar_index;
        r_q_err[i]   <= w_ar_err;
        r_q_cnt[i]   <= CNT_W'(RD_LAT - 1);
      end else if (r_q_cnt[i] != '0) begin
        r_q_cnt[i] <= r_q_cnt[i] - 1'b1;
      end
    end
  end

  // R output register: loads from the queue head, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rid    <= '0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_pop) begin
      r_rvalid <= 1'b1;
      r_rid    <= r_q_id[r_head];
      r_rresp  <= r_q_err[r_head] ? RESP_SLVERR : RESP_OKAY;
      r_rdata  <= r_q_err[r_head] ? '0 : r_mem[r_q_index[r_head]];
    end else if (rready_i) begin
      r_rvalid <= 1'b0;
    end
  end

  assign arready_o = w_arready;
  assign rvalid_o  = r_rvalid;
  assign rid_o     = r_rid;
  assign rresp_o   = r_rresp;
  assign rdata_o   = r_rdata;
  assign awready_o = r_awready;
  assign wready_o  = r_wready;
  assign bvalid_o  = r_bvalid;
  assign bid_o     = r_bid;
  assign bresp_o   = r_bresp;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed testbench for axi_slave_mem with default parameters.
module tb_axi_slave_mem;

  localparam int ADDR_W   = 64;
  localparam int DATA_W   = 512;
  localparam int ID_W     = 16;
  localparam int TAG_W    = 64;
  localparam int INDEX_W  = 10;
  localparam int OFFSET_W = 6;
  localparam int RD_LAT   = 4;
  localparam int AR_DEPTH = 4;
  localparam int LINE_W   = TAG_W + DATA_W;
  localparam int STRB_W   = DATA_W / 8;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b1;
  logic [ID_W-1:0]     arid_i    = '0;
  logic [ADDR_W-1:0]   araddr_i  = '0;
  logic                arvalid_i = 1'b0;
  logic                arready_o;
  logic [ID_W-1:0]     rid_o;
  logic [LINE_W-1:0]   rdata_o;
  logic [1:0]          rresp_o;
  logic                rvalid_o;
  logic                rready_i  = 1'b0;
  logic [ID_W-1:0]     awid_i    = '0;
  logic [ADDR_W-1:0]   awaddr_i  = '0;
  logic                awvalid_i = 1'b0;
  logic                awready_o;
  logic [DATA_W-1:0]   wdata_i   = '0;
  logic [STRB_W-1:0]   wstrb_i   = '0;
  logic [TAG_W-1:0]    wtag_i    = '0;
  logic                wvalid_i  = 1'b0;
  logic                wready_o;
  logic [ID_W-1:0]     bid_o;
  logic [1:0]          bresp_o;
  logic                bvalid_o;
  logic                bready_i  = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // Expected value of line 0x40 after the full write.
  localparam logic [LINE_W-1:0] LINE_40 = {64'h1122, {64{8'hA5}}};
  // Reset values of {arready, awready, wready, bvalid, rvalid, rresp, bresp}.
  localparam logic [8:0] CTRL_RESET = 9'b1_1_0_0_0_00_00;

  axi_slave_mem #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .TAG_W(TAG_W),
    .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W), .RD_LAT(RD_LAT), .AR_DEPTH(AR_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wtag_i(wtag_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance to 1 ns after the next rising edge (drive and sample point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                          input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb,
                          input logic [TAG_W-1:0] tag,
                          output logic [ID_W-1:0] bid, output logic [1:0] bresp);
    int n;
    awaddr_i = addr; awid_i = id; awvalid_i = 1'b1; n = 0;
    while (!awready_o && n < 50) begin tick(); n++; end
    tick();
    awvalid_i = 1'b0;
    wdata_i = data; wstrb_i = strb; wtag_i = tag; wvalid_i = 1'b1; n = 0;
    while (!wready_o && n < 50) begin tick(); n++; end
    tick();
    wvalid_i = 1'b0; n = 0;
    while (!bvalid_o && n < 50) begin tick(); n++; end
    if (!bvalid_o) begin
      compared++; mismatched++;
      $display("FAIL write_timeout: bvalid got 0 want 1 for addr %0h", addr);
    end
    bid = bid_o; bresp = bresp_o;
    bready_i = 1'b1;
    tick();
    bready_i = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                         output logic [LINE_W-1:0] line, output logic [ID_W-1:0] rid,
                         output logic [1:0] rresp);
    int n;
    araddr_i = addr; arid_i = id; arvalid_i = 1'b1; n = 0;
    while (!arready_o && n < 50) begin tick(); n++; end
    tick();
    arvalid_i = 1'b0; n = 0;
    while (!rvalid_o && n < 50) begin tick(); n++; end
    if (!rvalid_o) begin
      compared++; mismatched++;
      $display("FAIL read_timeout: rvalid got 0 want 1 for addr %0h", addr);
    end
    line = rdata_o; rid = rid_o; rresp = rresp_o;
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({arready_o, awready_o, wready_o, bvalid_o, rvalid_o, rresp_o, bresp_o} !== CTRL_RESET) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b want %b",
               {arready_o, awready_o, wready_o, bvalid_o, rvalid_o, rresp_o, bresp_o}, CTRL_RESET);
    end
    compared++;
    if (rid_o !== '0 || bid_o !== '0 || rdata_o !== '0) begin
      mismatched++;
      $display("FAIL reset_ids_data: rid %0h bid %0h rdata %0h want all 0", rid_o, bid_o, rdata_o);
    end
    #20 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_write_read();
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    do_write(64'h40, 16'h3, {64{8'hA5}}, '1, 64'h1122, bid, bresp);
    compared++;
    if (bid !== 16'h3 || bresp !== 2'b00) begin
      mismatched++;
      $display("FAIL full_write_b: bid %0h bresp %0b want 3 / 00", bid, bresp);
    end
    araddr_i = 64'h40; arid_i = 16'h7; arvalid_i = 1'b1;
    tick();                       // edge k: AR handshake
    arvalid_i = 1'b0;
    tick(); tick(); tick();       // edges k+1 .. k+3
    compared++;
    if (rvalid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL read_latency_early: rvalid got %0b want 0 after edge k+3", rvalid_o);
    end
    tick();                       // edge k+4
    compared++;
    if (rvalid_o !== 1'b1 || rid_o !== 16'h7 || rresp_o !== 2'b00) begin
      mismatched++;
      $display("FAIL read_latency: rvalid %0b rid %0h rresp %0b want 1 / 7 / 00", rvalid_o, rid_o, rresp_o);
    end
    compared++;
    if (rdata_o !== LINE_40) begin
      mismatched++;
      $display("FAIL full_read_data: got %0h want %0h", rdata_o, LINE_40);
    end
    rready_i = 1'b1;
    tick();
    rready_i = 1'b0;
    compared++;
    if (rvalid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL r_drain: rvalid got %0b want 0", rvalid_o);
    end
  endtask

  task automatic test_partial_strobe();
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [LINE_W-1:0] line;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    do_write(64'h80, 16'h1, '0, '1, 64'h55, bid, bresp);
    do_write(64'h80, 16'h2, 512'hFF, 64'h1, 64'h66, bid, bresp);
    do_read(64'h80, 16'h4, line, rid, rresp);
    compared++;
    if (line !== {64'h66, 512'hFF} || rid !== 16'h4 || rresp !== 2'b00) begin
      mismatched++;
      $display("FAIL partial_strobe: line %0h rid %0h rresp %0b want %0h / 4 / 00",
               line, rid, rresp, {64'h66, 512'hFF});
    end
  endtask

  task automatic test_back_to_back();
    rready_i = 1'b0;
    araddr_i = 64'h40; arvalid_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      arid_i = ID_W'(i);
      tick();
    end
    arvalid_i = 1'b0;
    compared++;
    if (arready_o !== 1'b0 || rvalid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL queue_full: arready %0b rvalid %0b want 0 / 0", arready_o, rvalid_o);
    end
    tick();                       // first entry pops into the empty R register
    compared++;
    if (arready_o !== 1'b1 || rvalid_o !== 1'b1 || rid_o !== 16'h1) begin
      mismatched++;
      $display("FAIL first_pop: arready %0b rvalid %0b rid %0h want 1 / 1 / 1", arready_o, rvalid_o, rid_o);
    end
    tick(); tick();
    compared++;
    if (rvalid_o !== 1'b1 || rid_o !== 16'h1 || rdata_o !== LINE_40) begin
      mismatched++;
      $display("FAIL r_hold: rvalid %0b rid %0h want 1 / 1 with line 0x40", rvalid_o, rid_o);
    end
    rready_i = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      compared++;
      if (rvalid_o !== 1'b1 || rid_o !== ID_W'(i)) begin
        mismatched++;
        $display("FAIL r_order: rvalid %0b rid %0h want 1 / %0h", rvalid_o, rid_o, i);
      end
    end
    tick();
    rready_i = 1'b0;
    compared++;
    if (rvalid_o !== 1'b0) begin
      mismatched++;
      $display("FAIL r_empty: rvalid got %0b want 0", rvalid_o);
    end
  endtask

  task automatic test_out_of_range();
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic [LINE_W-1:0] line;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    do_read(64'h10000, 16'h8, line, rid, rresp);
    compared++;
    if (rresp !== 2'b10 || line !== '0 || rid !== 16'h8) begin
      mismatched++;
      $display("FAIL oor_read: rresp %0b rdata %0h rid %0h want 10 / 0 / 8", rresp, line, rid);
    end
    do_write(64'h10000, 16'h9, '1, '1, '1, bid, bresp);
    compared++;
    if (bresp !== 2'b10 || bid !== 16'h9) begin
      mismatched++;
      $display("FAIL oor_write: bresp %0b bid %0h want 10 / 9", bresp, bid);
    end
    do_read(64'h0, 16'h1, line, rid, rresp);
    compared++;
    if (line !== '0 || rresp !== 2'b00) begin
      mismatched++;
      $display("FAIL oor_line0: rdata %0h rresp %0b want 0 / 00", line, rresp);
    end
  endtask

  task automatic test_reset_async();
    // Leave a write in W_DATA and a loaded R beat, then reset between edges.
    awaddr_i = 64'h40; awid_i = 16'h5; awvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0;
    araddr_i = 64'h40; arid_i = 16'hA; arvalid_i = 1'b1;
    tick();
    arvalid_i = 1'b0;
    tick(); tick(); tick(); tick();
    compared++;
    if (wready_o !== 1'b1 || rvalid_o !== 1'b1 || rid_o !== 16'hA || bid_o !== 16'h5) begin
      mismatched++;
      $display("FAIL pre_reset: wready %0b rvalid %0b rid %0h bid %0h want 1 / 1 / a / 5",
               wready_o, rvalid_o, rid_o, bid_o);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if ({arready_o, awready_o, wready_o, bvalid_o, rvalid_o, rresp_o, bresp_o} !== CTRL_RESET) begin
      mismatched++;
      $display("FAIL async_reset_ctrl: got %b want %b",
               {arready_o, awready_o, wready_o, bvalid_o, rvalid_o, rresp_o, bresp_o}, CTRL_RESET);
    end
    compared++;
    if (rid_o !== '0 || bid_o !== '0 || rdata_o !== '0) begin
      mismatched++;
      $display("FAIL async_reset_ids_data: rid %0h bid %0h rdata %0h want all 0", rid_o, bid_o, rdata_o);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_pending();
    int                seen;
    logic [LINE_W-1:0] line;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    rready_i = 1'b0;
    araddr_i = 64'h40; arvalid_i = 1'b1;
    arid_i = 16'hB; tick();
    arid_i = 16'hC; tick();
    arvalid_i = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    rready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rvalid_o) seen++;
    end
    rready_i = 1'b0;
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL reset_flush: saw %0d R beats want 0", seen);
    end
    do_read(64'h40, 16'hD, line, rid, rresp);
    compared++;
    if (line !== LINE_40 || rid !== 16'hD || rresp !== 2'b00) begin
      mismatched++;
      $display("FAIL reset_retain: line %0h rid %0h rresp %0b want %0h / d / 00", line, rid, rresp, LINE_40);
    end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_strobe();
    test_back_to_back();
    test_out_of_range();
    test_reset_async();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Parametrised AXI slave memory model for the DRAM-cache / CXL testbench. It is the next generation of the single-outstanding CXL slave model. It adds:
- configurable line, tag, index and ID widths
- byte-strobed writes
- an outstanding-read queue with a programmable fixed read latency
- ID echo on R and B
- out-of-range error responses

It sits behind the cache controller's AXI master port and stands in for the backing store. Each line returns `{tag, data}`.

## Interface
- `ADDR_W`, 64, address width
- `DATA_W`, 512, line data width (multiple of 8)
- `ID_W`, 16, transaction ID width
- `TAG_W`, 64, tag/metadata field stored per line
- `INDEX_W`, 10, line index bits; depth = 2^INDEX_W lines
- `OFFSET_W`, 6, byte-offset bits below the index
- `RD_LAT`, 4, cycles from AR handshake to earliest rvalid (≥1)
- `AR_DEPTH`, 4, outstanding read queue depth (power of 2, ≥2)

Ports:
- `clk` in 1: single clock, all logic on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `arid_i` in ID_W, `araddr_i` in ADDR_W, `arvalid_i` in 1, `arready_o` out 1: AR channel
- `rid_o` out ID_W, `rdata_o` out TAG_W+DATA_W (`{tag, data}`), `rresp_o` out 2, `rvalid_o` out 1, `rready_i` in 1: R channel
- `awid_i` in ID_W, `awaddr_i` in ADDR_W, `awvalid_i` in 1, `awready_o` out 1: AW channel
- `wdata_i` in DATA_W, `wstrb_i` in DATA_W/8, `wtag_i` in TAG_W, `wvalid_i` in 1, `wready_o` out 1: W channel
- `bid_o` out ID_W, `bresp_o` out 2, `bvalid_o` out 1, `bready_i` in 1: B channel

## Operation
- **Memory array:** 2^INDEX_W entries of TAG_W+DATA_W bits. Initialised to zero at time 0. Reset does not clear it.
- **Index and range:** index = `addr[INDEX_W+OFFSET_W-1:OFFSET_W]`. Offset bits are ignored. Any nonzero bit in `addr[ADDR_W-1:INDEX_W+OFFSET_W]` makes the address out of range, giving response 2'b10 (SLVERR). Otherwise the response is 2'b00.
- **Write FSM:** states W_IDLE, W_DATA, W_RESP. One write is in flight at a time.
  - W_IDLE: `awready_o`=1. On AW handshake, capture id, index and range flag, then go to W_DATA.
  - W_DATA: `wready_o`=1. On W handshake with an in-range address, write data byte i when `wstrb_i[i]`=1, and write the tag field with `wtag_i` unconditionally. Out-of-range writes are dropped. Go to W_RESP.
  - W_RESP: `bvalid_o`=1, with `bid_o` and `bresp_o` set from the capture. On `bready_i`, go to W_IDLE.
- **Read queue:** FIFO of AR_DEPTH entries, each holding {id, index, range flag, latency countdown}.
  - `arready_o` = (count != AR_DEPTH). There is no pass-through when full.
  - The countdown is loaded with RD_LAT-1 on push and decrements each cycle to a floor of 0.
- **R output register:**
  - When the R register is empty, or is being handshaken this cycle, and the head entry's countdown is 0, the head is popped.
  - The popped entry loads `rid_o`, `rresp_o`, `rvalid_o`=1, and `rdata_o`. `rdata_o` is the array line as of that edge, or all-zero for out-of-range entries.
  - The payload is held stable while `rvalid_o`=1 and `rready_i`=0.
- **Ordering:** R beats return in AR acceptance order. Reads and writes are independent. A write committed at edge k is visible to any R load at edge k+1 or later.

## Timing
- **Reset values:** `arready_o`=1, `awready_o`=1, `wready_o`=0, `bvalid_o`=0, `rvalid_o`=0. `rid_o`, `rdata_o`, `rresp_o`, `bid_o` and `bresp_o` are all 0.
- **Read latency:** for an AR accepted at edge k with an idle R path, `rvalid_o` rises after edge k+RD_LAT.
- **Read throughput:** with `rready_i` held high, one R beat per cycle.
- **AR backpressure:** when the queue is full, `arready_o` drops after the edge of the filling push. It rises after the edge of the first pop.
- **Write timing:** AW handshake at edge k gives `wready_o` after edge k. W handshake at edge j gives `bvalid_o` after edge j. `awready_o` returns after the B handshake edge.
- **Reset asserted mid-operation:** all outputs take their reset values immediately (asynchronously). Queued reads and any uncommitted write are discarded. Committed array data is retained.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-simulation -> all outputs take their reset values in the same cycle, without waiting for a clock edge.
- **Full write then read:** write awaddr 0x40, awid 0x3, wdata all-0xA5, wstrb all-ones, wtag 0x1122 -> bid 0x3, bresp 0. Then AR araddr 0x40, arid 0x7 at edge k -> `rvalid_o` after edge k+4, rid 0x7, rdata = {64'h1122, {64{8'hA5}}}, rresp 0.
- **Partial strobe:** write 0x80 all-zero with full strobe, then write wdata 0xFF in byte 0 with wstrb=0x1 -> a read of 0x80 returns data byte 0 = 0xFF and all other bytes 0x00.
- **Queue backpressure and order:** four back-to-back ARs, ids 1..4, with `rready_i`=0 -> `arready_o` low after the 4th. Raise `rready_i` -> R ids 1, 2, 3, 4 on consecutive cycles, and `arready_o` high after the first pop.
- **Out of range:** araddr 0x10000 -> rresp 2'b10, rdata 0. awaddr 0x10000 with data 0xFF -> bresp 2'b10, and a subsequent read of line 0 is unchanged.
- **Reset with reads pending:** reset while 2 ARs are pending -> no R beats after release. Data previously written to 0x40 is still returned by a fresh read.
